exec_arbiter: RTL and testbench

Issue controller that shares the single execute unit (2x2 ALU, condition evaluator and flag writer) between two command requesters: requester 0 is the main decode stage and requester 1 is the auxiliary sequencer (exception/debug micro-ops). It arbitrates round-robin with optional grant locking and registers the granted command onto the execute inputs. It enforces a one-cycle flag hazard between a flag-writing op and a following conditional op, and returns a response strobe aligned with the execute stage's registered results.

---
 rtl/exec_arbiter_if.sv | 57 +++++
 rtl/exec_arbiter.sv | 101 ++++++++++
 tb/tb_exec_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_arbiter_if.sv
// rtl/exec_arbiter_if.sv - requester, execute-issue and response signals of exec_arbiter
interface exec_arbiter_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic [7:0]  r0_alu_op;
    logic        r0_is_cond;
    logic [3:0]  r0_cond;
    logic [3:0]  r0_write_flags;
    logic        r0_swp;
    logic        r0_lock;

    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [7:0]  r1_alu_op;
    logic        r1_is_cond;
    logic [3:0]  r1_cond;
    logic [3:0]  r1_write_flags;
    logic        r1_swp;
    logic        r1_lock;

    logic        hold;

    logic        ex_valid;
    logic        ex_id;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [7:0]  ex_alu_op;
    logic        ex_is_cond;
    logic [3:0]  ex_cond;
    logic [3:0]  ex_write_flags;
    logic        ex_swp;

    logic        rsp_valid;
    logic        rsp_id;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_alu_op, r0_is_cond, r0_cond, r0_write_flags, r0_swp, r0_lock,
        input  r1_valid, r1_a, r1_b, r1_alu_op, r1_is_cond, r1_cond, r1_write_flags, r1_swp, r1_lock,
        input  hold,
        output r0_ready, r1_ready,
        output ex_valid, ex_id, ex_a, ex_b, ex_alu_op, ex_is_cond, ex_cond, ex_write_flags, ex_swp,
        output rsp_valid, rsp_id
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_alu_op, r0_is_cond, r0_cond, r0_write_flags, r0_swp, r0_lock,
        output r1_valid, r1_a, r1_b, r1_alu_op, r1_is_cond, r1_cond, r1_write_flags, r1_swp, r1_lock,
        output hold,
        input  r0_ready, r1_ready,
        input  ex_valid, ex_id, ex_a, ex_b, ex_alu_op, ex_is_cond, ex_cond, ex_write_flags, ex_swp,
        input  rsp_valid, rsp_id
    );
endinterface

// File: rtl/exec_arbiter.sv
// rtl/exec_arbiter.sv - round-robin issue of two requesters onto the execute unit, flag hazard, optional EXEC_ARB_LOCK_EN grant lock
module exec_arbiter (
    input  logic          clk,
    input  logic          rst,
    exec_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t state_q, state_d;
    logic   last_q;
    logic   fh;
    logic   lock_ok0, lock_ok1;
    logic   elig0, elig1, gnt0, gnt1, gnt_any;

    // The command sitting in ex_* is the previous cycle's grant, so its flag write blocks conditionals now.
    assign fh = bus.ex_valid && (bus.ex_write_flags != 4'd0);

`ifdef EXEC_ARB_LOCK_EN
    logic lock_on_q, lock_id_q;

    assign lock_ok0 = !lock_on_q || !lock_id_q;
    assign lock_ok1 = !lock_on_q ||  lock_id_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_on_q <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (gnt_any) begin
            lock_on_q <= gnt1 ? bus.r1_lock : bus.r0_lock;
            lock_id_q <= gnt1;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = bus.r0_lock ^ bus.r1_lock;
    assign lock_ok0    = 1'b1;
    assign lock_ok1    = 1'b1;
`endif

    assign elig0   = bus.r0_valid && !bus.hold && !(fh && bus.r0_is_cond) && lock_ok0;
    assign elig1   = bus.r1_valid && !bus.hold && !(fh && bus.r1_is_cond) && lock_ok1;
    assign gnt0    = elig0 && (!elig1 ||  last_q);
    assign gnt1    = elig1 && (!elig0 || !last_q);
    assign gnt_any = gnt0 || gnt1;

    // Ready is masked by reset so no handshake can be seen while the block is held in reset.
    assign bus.r0_ready = gnt0 && rst;
    assign bus.r1_ready = gnt1 && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (gnt_any) state_d = ISSUE;
    end

    always_comb begin
        bus.ex_valid = (state_q == ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q             <= 1'b1;
            bus.ex_id          <= 1'b0;
            bus.ex_a           <= 32'd0;
            bus.ex_b           <= 32'd0;
            bus.ex_alu_op      <= 8'd0;
            bus.ex_is_cond     <= 1'b0;
            bus.ex_cond        <= 4'd0;
            bus.ex_write_flags <= 4'd0;
            bus.ex_swp         <= 1'b0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_id         <= 1'b0;
        end else begin
            bus.rsp_valid <= bus.ex_valid;
            bus.rsp_id    <= bus.ex_id;
            if (gnt_any) begin
                last_q             <= gnt1;
                bus.ex_id          <= gnt1;
                bus.ex_a           <= gnt1 ? bus.r1_a           : bus.r0_a;
                bus.ex_b           <= gnt1 ? bus.r1_b           : bus.r0_b;
                bus.ex_alu_op      <= gnt1 ? bus.r1_alu_op      : bus.r0_alu_op;
                bus.ex_is_cond     <= gnt1 ? bus.r1_is_cond     : bus.r0_is_cond;
                bus.ex_cond        <= gnt1 ? bus.r1_cond        : bus.r0_cond;
                bus.ex_write_flags <= gnt1 ? bus.r1_write_flags : bus.r0_write_flags;
                bus.ex_swp         <= gnt1 ? bus.r1_swp         : bus.r0_swp;
            end else begin
                // Bubble issues a NOP that writes no flags; operands and id are left as they were.
                bus.ex_alu_op      <= 8'd0;
                bus.ex_is_cond     <= 1'b0;
                bus.ex_cond        <= 4'd0;
                bus.ex_write_flags <= 4'd0;
                bus.ex_swp         <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exec_arbiter.sv
// tb/tb_exec_arbiter.sv - scoreboard bench for exec_arbiter
module tb_exec_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    exec_arbiter_if bus ();

    exec_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [17:0] ctl;
    } ex_exp_t;

    typedef struct {
        int   due;
        logic id;
    } rsp_exp_t;

    ex_exp_t  ex_q[$];
    rsp_exp_t rsp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.r0_valid = 0; bus.r0_a = 0; bus.r0_b = 0; bus.r0_alu_op = 0; bus.r0_is_cond = 0;
        bus.r0_cond = 0; bus.r0_write_flags = 0; bus.r0_swp = 0; bus.r0_lock = 0;
        bus.r1_valid = 0; bus.r1_a = 0; bus.r1_b = 0; bus.r1_alu_op = 0; bus.r1_is_cond = 0;
        bus.r1_cond = 0; bus.r1_write_flags = 0; bus.r1_swp = 0; bus.r1_lock = 0;
        bus.hold = 0;
    endtask

    task automatic drive(input bit k, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] op, input logic ic, input logic [3:0] cnd,
                         input logic [3:0] wf, input logic lk);
        if (k == 1'b0) begin
            bus.r0_valid = v; bus.r0_a = a; bus.r0_b = b; bus.r0_alu_op = op; bus.r0_is_cond = ic;
            bus.r0_cond = cnd; bus.r0_write_flags = wf; bus.r0_swp = a[0]; bus.r0_lock = lk;
        end else begin
            bus.r1_valid = v; bus.r1_a = a; bus.r1_b = b; bus.r1_alu_op = op; bus.r1_is_cond = ic;
            bus.r1_cond = cnd; bus.r1_write_flags = wf; bus.r1_swp = a[0]; bus.r1_lock = lk;
        end
    endtask

    task automatic expect_ready(input string tag, input logic e0, input logic e1);
        @(negedge clk);
        check({tag, "_r0_ready"}, bus.r0_ready, e0);
        check({tag, "_r1_ready"}, bus.r1_ready, e1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Monitor: compares ex_* one cycle and rsp_* two cycles after each observed handshake.
    always @(negedge clk) begin
        ex_exp_t  e;
        rsp_exp_t r;
        if (!rst) begin
            ex_q.delete();
            rsp_q.delete();
        end else begin
            if (ex_q.size() > 0 && ex_q[0].due == cyc) begin
                e = ex_q.pop_front();
                check("ex_valid", bus.ex_valid, 1);
                check("ex_id", bus.ex_id, e.id);
                check("ex_a", bus.ex_a, e.a);
                check("ex_b", bus.ex_b, e.b);
                check("ex_ctl", {bus.ex_alu_op, bus.ex_is_cond, bus.ex_cond, bus.ex_write_flags, bus.ex_swp}, e.ctl);
            end else begin
                check("ex_idle", bus.ex_valid, 0);
                check("ex_nop", {bus.ex_alu_op, bus.ex_is_cond, bus.ex_cond, bus.ex_write_flags, bus.ex_swp}, 0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                check("rsp_valid", bus.rsp_valid, 1);
                check("rsp_id", bus.rsp_id, r.id);
            end else begin
                check("rsp_idle", bus.rsp_valid, 0);
            end
            if (bus.r0_valid && bus.r0_ready) begin
                ex_q.push_back('{cyc + 1, 1'b0, bus.r0_a, bus.r0_b,
                                 {bus.r0_alu_op, bus.r0_is_cond, bus.r0_cond, bus.r0_write_flags, bus.r0_swp}});
                rsp_q.push_back('{cyc + 2, 1'b0});
            end
            if (bus.r1_valid && bus.r1_ready) begin
                ex_q.push_back('{cyc + 1, 1'b1, bus.r1_a, bus.r1_b,
                                 {bus.r1_alu_op, bus.r1_is_cond, bus.r1_cond, bus.r1_write_flags, bus.r1_swp}});
                rsp_q.push_back('{cyc + 2, 1'b1});
            end
        end
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        idle();
        bus.r0_valid = 1;
        tick();
        tick();
        @(negedge clk);
        check("rst_r0_ready", bus.r0_ready, 0);
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_ex_a", bus.ex_a, 0);
        tick();
        rst = 1'b1;
        idle();
        tick();

        // Single command from requester 0
        drive(0, 1, 32'd5, 32'd3, 8'h01, 0, 4'd0, 4'd0, 0);
        expect_ready("single", 1, 0);
        tick();
        idle();
        repeat (3) tick();

        // Contention right after reset: requester 0 wins the first tie
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h100 + i, 32'h10, 8'h02, 0, 4'd0, 4'd0, 0);
            drive(1, 1, 32'h200 + i, 32'h20, 8'h03, 0, 4'd0, 4'd0, 0);
            expect_ready("rr", (i % 2) == 0, (i % 2) == 1);
            tick();
        end
        idle();
        repeat (3) tick();

        // Flag hazard: conditional op right after a flag writer waits one bubble
        drive(0, 1, 32'h11, 32'h22, 8'h01, 0, 4'd0, 4'hF, 0);
        expect_ready("hz1_flag", 1, 0);
        tick();
        drive(0, 1, 32'h33, 32'h44, 8'h04, 1, 4'd0, 4'd0, 0);
        expect_ready("hz1_block", 0, 0);
        tick();
        expect_ready("hz1_grant", 1, 0);
        tick();
        idle();
        repeat (2) tick();

        // Flag hazard: other requester's non-conditional op goes through the bubble slot
        drive(0, 1, 32'h55, 32'h66, 8'h01, 0, 4'd0, 4'hF, 0);
        expect_ready("hz2_flag", 1, 0);
        tick();
        drive(0, 1, 32'h77, 32'h88, 8'h04, 1, 4'd0, 4'd0, 0);
        drive(1, 1, 32'h99, 32'hAA, 8'h05, 0, 4'd0, 4'd0, 0);
        expect_ready("hz2_other", 0, 1);
        tick();
        drive(1, 0, 32'h0, 32'h0, 8'h00, 0, 4'd0, 4'd0, 0);
        expect_ready("hz2_cond", 1, 0);
        tick();
        idle();
        repeat (2) tick();

        // Hold: no grants while asserted, NOP on execute
        bus.hold = 1;
        drive(0, 1, 32'hB0, 32'hB1, 8'h06, 0, 4'd0, 4'h3, 0);
        drive(1, 1, 32'hC0, 32'hC1, 8'h07, 0, 4'd0, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            expect_ready("hold", 0, 0);
            tick();
        end
        bus.hold = 0;
        expect_ready("hold_release", 0, 1);
        tick();
        idle();
        repeat (2) tick();

        // Grant lock held by requester 1
        drive(1, 1, 32'hD0, 32'hD1, 8'h08, 0, 4'd0, 4'd0, 1);
        expect_ready("lock_set", 0, 1);
        tick();
        drive(1, 0, 32'h0, 32'h0, 8'h00, 0, 4'd0, 4'd0, 0);
        drive(0, 1, 32'hE0, 32'hE1, 8'h09, 0, 4'd0, 4'd0, 0);
        for (int i = 0; i < 2; i++) begin
`ifdef EXEC_ARB_LOCK_EN
            expect_ready("lock_hold", 0, 0);
`else
            expect_ready("nolock_pass", 1, 0);
`endif
            tick();
        end
        drive(1, 1, 32'hF0, 32'hF1, 8'h0A, 0, 4'd0, 4'd0, 0);
        expect_ready("lock_release", 0, 1);
        tick();
        drive(1, 0, 32'h0, 32'h0, 8'h00, 0, 4'd0, 4'd0, 0);
        expect_ready("lock_after", 1, 0);
        tick();
        idle();
        repeat (2) tick();

        // Reset with a command in flight
        drive(0, 1, 32'hDEAD, 32'hBEEF, 8'h0B, 0, 4'd0, 4'h1, 0);
        expect_ready("mid_hs", 1, 0);
        tick();
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_ex_valid", bus.ex_valid, 0);
        check("mid_rsp_valid", bus.rsp_valid, 0);
        check("mid_ex_a", bus.ex_a, 0);
        check("mid_ex_ctl", {bus.ex_alu_op, bus.ex_is_cond, bus.ex_cond, bus.ex_write_flags, bus.ex_swp}, 0);
        tick();
        rst = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
